// File: rtl/nv_ram_rwsp_param.sv
// nv_ram_rwsp_param: one-write/one-read synchronous RAM model with per-byte
// write mask, selectable write-through on address collision, optional output
// register and a read-valid strobe. The storage array is never reset; only the
// read path is.
module nv_ram_rwsp_param #(
    parameter int DW      = 128,
    parameter int AW      = 9,
    parameter int DEPTH   = 512,
    parameter int OUT_REG = 0,
    parameter int BYPASS  = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [AW-1:0]   ra,
    input  logic            re,
    output logic [DW-1:0]   dout,
    output logic            dout_vld,
    input  logic [AW-1:0]   wa,
    input  logic            we,
    input  logic [DW-1:0]   di,
    input  logic [DW/8-1:0] wmask,
    input  logic [31:0]     pwrbus_ram_pd
);

    localparam int NB = DW / 8;
    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic          wr_ok;
    logic          ra_ok;
    logic          collide;
    logic [DW-1:0] rd_next;
    logic [DW-1:0] rd_q;
    logic          rd_vld_q;

    // Power-bus control has no behavioural effect in the model.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    assign wr_ok   = we && ({1'b0, wa} < DEPTH_C);
    assign ra_ok   = {1'b0, ra} < DEPTH_C;
    assign collide = we && (ra == wa);

    // Byte-masked write; out-of-range addresses leave the array untouched.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask[i]) begin
                    mem[wa][8*i +: 8] <= di[8*i +: 8];
                end
            end
        end
    end

    // Read data selection: zero when out of range, optional write-through merge.
    always_comb begin
        rd_next = '0;
        if (ra_ok) begin
            rd_next = mem[ra];
            if (collide && (BYPASS != 0)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wmask[i]) begin
                        rd_next[8*i +: 8] = di[8*i +: 8];
                    end
                end
            end
        end
    end

    // Stage-1 read register; holds its snapshot while re is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= re;
            if (re) begin
                rd_q <= rd_next;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] out_q;
            logic          out_vld_q;

            // Second stage only loads when a fresh stage-1 result is present.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    out_q     <= '0;
                    out_vld_q <= 1'b0;
                end else begin
                    out_vld_q <= rd_vld_q;
                    if (rd_vld_q) begin
                        out_q <= rd_q;
                    end
                end
            end

            assign dout     = out_q;
            assign dout_vld = out_vld_q;
        end else begin : g_out_direct
            assign dout     = rd_q;
            assign dout_vld = rd_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Directed testbench for nv_ram_rwsp_param. Two default-size instances share
// stimulus (write-through and read-old-data collision modes); a third small
// instance uses the output register and a non-power-of-two depth.
module tb_nv_ram_rwsp_param;

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  pwr = 32'h0;

    logic [8:0]   ra, wa;
    logic         re, we;
    logic [127:0] di;
    logic [15:0]  wmask;
    logic [127:0] dout_a, dout_b;
    logic         vld_a, vld_b;

    logic [3:0]   ra2, wa2;
    logic         re2, we2;
    logic [31:0]  di2;
    logic [3:0]   wmask2;
    logic [31:0]  dout_c;
    logic         vld_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nv_ram_rwsp_param #(.DW(128), .AW(9), .DEPTH(512), .OUT_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
        .wa(wa), .we(we), .di(di), .wmask(wmask), .pwrbus_ram_pd(pwr)
    );

    nv_ram_rwsp_param #(.DW(128), .AW(9), .DEPTH(512), .OUT_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
        .wa(wa), .we(we), .di(di), .wmask(wmask), .pwrbus_ram_pd(pwr)
    );

    nv_ram_rwsp_param #(.DW(32), .AW(4), .DEPTH(10), .OUT_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rstn(rstn), .ra(ra2), .re(re2), .dout(dout_c), .dout_vld(vld_c),
        .wa(wa2), .we(we2), .di(di2), .wmask(wmask2), .pwrbus_ram_pd(pwr)
    );

    function automatic logic [127:0] pat(input int a);
        logic [31:0] v;
        v = 32'(a);
        return {v + 32'h1000, ~v, v * 32'd3, v ^ 32'h5A5A5A5A};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re = 1'b0; we = 1'b0; re2 = 1'b0; we2 = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        ra = '0; wa = '0; di = '0; wmask = '0;
        ra2 = '0; wa2 = '0; di2 = '0; wmask2 = '0;
        rstn = 1'b0;
        #12;
        checks++;
        if (dout_a !== 128'h0 || vld_a !== 1'b0 || dout_c !== 32'h0 || vld_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dout_a=%h vld_a=%b dout_c=%h vld_c=%b required zeros",
                     dout_a, vld_a, dout_c, vld_c);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        checks++;
        if (dout_a !== 128'h0 || vld_a !== 1'b0 || dout_b !== 128'h0 || vld_c !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle dout_a=%h vld_a=%b dout_b=%h vld_c=%b required zeros",
                     dout_a, vld_a, dout_b, vld_c);
        end
    endtask

    task automatic test_fill_read();
        int run;
        we = 1'b1; wmask = 16'hFFFF;
        for (int a = 0; a < 512; a++) begin
            wa = 9'(a); di = pat(a);
            tick();
        end
        we = 1'b0;
        run = 0;
        re = 1'b1;
        for (int a = 0; a < 512; a++) begin
            ra = 9'(a);
            tick();
            if (vld_a === 1'b1) run++;
            checks++;
            if (dout_a !== pat(a) || vld_a !== 1'b1) begin
                errors++;
                $display("FAIL fill_read addr=%0d got=%h vld=%b required=%h vld=1",
                         a, dout_a, vld_a, pat(a));
            end
        end
        re = 1'b0;
        tick();
        checks++;
        if (run != 512 || vld_a !== 1'b0 || dout_a !== pat(511)) begin
            errors++;
            $display("FAIL fill_read_end run=%0d vld=%b dout=%h required run=512 vld=0 dout=%h",
                     run, vld_a, dout_a, pat(511));
        end
    endtask

    task automatic test_byte_mask();
        we = 1'b1; wa = 9'd5; di = {128{1'b1}}; wmask = 16'hFFFF;
        tick();
        di = 128'h0; wmask = 16'h00FF;
        tick();
        we = 1'b0; re = 1'b1; ra = 9'd5;
        tick();
        re = 1'b0;
        checks++;
        if (dout_a !== {64'hFFFF_FFFF_FFFF_FFFF, 64'h0} || vld_a !== 1'b1) begin
            errors++;
            $display("FAIL byte_mask got=%h vld=%b required=%h vld=1",
                     dout_a, vld_a, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        end
    endtask

    task automatic test_collision();
        we = 1'b1; wa = 9'd7; di = {16{8'hAA}}; wmask = 16'hFFFF;
        tick();
        re = 1'b1; ra = 9'd7; di = {16{8'h55}}; wmask = 16'h00FF;
        tick();
        we = 1'b0;
        checks++;
        if (dout_a !== {{8{8'hAA}}, {8{8'h55}}}) begin
            errors++;
            $display("FAIL collide_bypass got=%h required=%h", dout_a, {{8{8'hAA}}, {8{8'h55}}});
        end
        checks++;
        if (dout_b !== {16{8'hAA}}) begin
            errors++;
            $display("FAIL collide_old got=%h required=%h", dout_b, {16{8'hAA}});
        end
        tick();
        re = 1'b0;
        checks++;
        if (dout_a !== {{8{8'hAA}}, {8{8'h55}}} || dout_b !== {{8{8'hAA}}, {8{8'h55}}}) begin
            errors++;
            $display("FAIL collide_reread a=%h b=%h required=%h",
                     dout_a, dout_b, {{8{8'hAA}}, {8{8'h55}}});
        end
    endtask

    task automatic test_out_reg();
        we2 = 1'b1; wmask2 = 4'hF;
        wa2 = 4'd2;  di2 = 32'h2222_2222; tick();
        wa2 = 4'd3;  di2 = 32'h3333_3333; tick();
        wa2 = 4'd9;  di2 = 32'h9999_9999; tick();
        wa2 = 4'd12; di2 = 32'hCCCC_CCCC; tick();
        we2 = 1'b0;
        re2 = 1'b1; ra2 = 4'd3;
        tick();
        checks++;
        if (vld_c !== 1'b0 || dout_c !== 32'h0) begin
            errors++;
            $display("FAIL outreg_n1 got=%h vld=%b required=0 vld=0", dout_c, vld_c);
        end
        ra2 = 4'd12; tick();
        checks++;
        if (vld_c !== 1'b1 || dout_c !== 32'h3333_3333) begin
            errors++;
            $display("FAIL outreg_a3 got=%h vld=%b required=33333333 vld=1", dout_c, vld_c);
        end
        ra2 = 4'd9; tick();
        checks++;
        if (vld_c !== 1'b1 || dout_c !== 32'h0) begin
            errors++;
            $display("FAIL outreg_a12 got=%h vld=%b required=0 vld=1", dout_c, vld_c);
        end
        re2 = 1'b0; tick();
        checks++;
        if (vld_c !== 1'b1 || dout_c !== 32'h9999_9999) begin
            errors++;
            $display("FAIL outreg_a9 got=%h vld=%b required=99999999 vld=1", dout_c, vld_c);
        end
        tick();
        checks++;
        if (vld_c !== 1'b0 || dout_c !== 32'h9999_9999) begin
            errors++;
            $display("FAIL outreg_hold got=%h vld=%b required=99999999 vld=0", dout_c, vld_c);
        end
        re2 = 1'b1; ra2 = 4'd2; tick();
        re2 = 1'b0; tick();
        checks++;
        if (vld_c !== 1'b1 || dout_c !== 32'h2222_2222) begin
            errors++;
            $display("FAIL outreg_no_alias got=%h vld=%b required=22222222 vld=1", dout_c, vld_c);
        end
    endtask

    task automatic test_reset_mid_read();
        int pulses;
        re = 1'b1; ra = 9'd5; re2 = 1'b1; ra2 = 4'd9;
        tick();
        re = 1'b0; re2 = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (dout_a !== 128'h0 || vld_a !== 1'b0 || dout_c !== 32'h0 || vld_c !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear dout_a=%h vld_a=%b dout_c=%h vld_c=%b required zeros",
                     dout_a, vld_a, dout_c, vld_c);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (vld_c !== 1'b0 || vld_a !== 1'b0) pulses++;
        end
        rstn = 1'b1;
        tick();
        if (vld_c !== 1'b0 || dout_c !== 32'h0) pulses++;
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_pulse count=%0d required=0", pulses);
        end
        re = 1'b1; ra = 9'd5; re2 = 1'b1; ra2 = 4'd3;
        tick();
        re = 1'b0; re2 = 1'b0;
        checks++;
        if (dout_a !== {64'hFFFF_FFFF_FFFF_FFFF, 64'h0} || vld_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_keep_a got=%h vld=%b required=%h", dout_a, vld_a,
                     {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        end
        tick();
        checks++;
        if (dout_c !== 32'h3333_3333 || vld_c !== 1'b1) begin
            errors++;
            $display("FAIL midreset_keep_c got=%h vld=%b required=33333333 vld=1", dout_c, vld_c);
        end
    endtask

    task automatic test_snapshot();
        logic [127:0] va, vb;
        va = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        vb = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
        we = 1'b1; wa = 9'd2; di = va; wmask = 16'hFFFF;
        tick();
        we = 1'b0; re = 1'b1; ra = 9'd2;
        tick();
        re = 1'b0; we = 1'b1; di = vb;
        checks++;
        if (dout_a !== va || vld_a !== 1'b1) begin
            errors++;
            $display("FAIL snap_first got=%h vld=%b required=%h", dout_a, vld_a, va);
        end
        tick();
        we = 1'b0;
        checks++;
        if (dout_a !== va || vld_a !== 1'b0) begin
            errors++;
            $display("FAIL snap_hold got=%h vld=%b required=%h vld=0", dout_a, vld_a, va);
        end
        tick();
        checks++;
        if (dout_a !== va || dout_b !== va) begin
            errors++;
            $display("FAIL snap_hold2 a=%h b=%h required=%h", dout_a, dout_b, va);
        end
        re = 1'b1;
        tick();
        re = 1'b0;
        checks++;
        if (dout_a !== vb || vld_a !== 1'b1) begin
            errors++;
            $display("FAIL snap_new got=%h vld=%b required=%h", dout_a, vld_a, vb);
        end
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_byte_mask();
        test_collision();
        test_out_reg();
        test_reset_mid_read();
        test_snapshot();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
